// File: rtl/mem_responder.sv
// Word-addressed memory target with programmable wait states before each response.
// A request is latched in IDLE, waits WAIT_CYCLES edges, then completes with a one-cycle ack.
module mem_responder #(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [8:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ack_q;
    logic        busy_q;
    logic [31:0] mem_q [0:DEPTH-1];

    logic        txn_we_s;
    logic [8:0]  txn_addr_s;
    logic [31:0] txn_wdata_s;
    logic        go_resp_s;
    logic        in_range_s;
    logic [31:0] rd_word_s;

    // With zero wait states the access happens on the accepting edge, so use live inputs in IDLE.
    always_comb begin
        txn_we_s    = we_q;
        txn_addr_s  = addr_q;
        txn_wdata_s = wdata_q;
        if (state_q == S_IDLE) begin
            txn_we_s    = we;
            txn_addr_s  = addr;
            txn_wdata_s = wdata;
        end else begin
            txn_we_s    = we_q;
            txn_addr_s  = addr_q;
            txn_wdata_s = wdata_q;
        end
        case (state_q)
            S_IDLE:  go_resp_s = req && (WAIT_CYCLES == 0);
            S_WAIT:  go_resp_s = (cnt_q == 4'd0);
            default: go_resp_s = 1'b0;
        endcase
        in_range_s = ({23'd0, txn_addr_s} < 32'(DEPTH));
        rd_word_s  = in_range_s ? mem_q[txn_addr_s[AW-1:0]] : 32'h0000_0000;
    end

    // Transaction FSM with registered ack/busy/rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 9'd0;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= go_resp_s;
            if (go_resp_s && !txn_we_s) begin
                rdata_q <= rd_word_s;
            end
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= WAIT_LOAD;
                        state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    busy_q <= 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array is deliberately not reset; a reset aborts any write still pending.
    always_ff @(posedge clk) begin
        if (!rst && go_resp_s && txn_we_s && in_range_s) begin
            mem_q[txn_addr_s[AW-1:0]] <= txn_wdata_s;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance A uses two wait states and DEPTH=256, instance B uses zero wait states.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_a, we_a, req_b, we_b;
    logic [8:0]  addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, busy_a, ack_b, busy_b;

    int n_checks;
    int n_pass;

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ack(ack_a), .busy(busy_a)
    );

    mem_responder #(.DEPTH(512), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ack(ack_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full two-wait-state transaction on A; inputs are scrambled while busy.
    task automatic txn_a(input string tag, input logic w, input logic [8:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd);
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        step();
        check({tag, "_busy0"}, busy_a, 1'b1);
        check({tag, "_ack0"}, ack_a, 1'b0);
        req_a = 1'b0; we_a = ~w; addr_a = ~a; wdata_a = ~d;
        step();
        check({tag, "_busy1"}, busy_a, 1'b1);
        check({tag, "_ack1"}, ack_a, 1'b0);
        step();
        check({tag, "_ack2"}, ack_a, 1'b1);
        check({tag, "_rdata2"}, rdata_a, exp_rd);
        step();
        check({tag, "_ack3"}, ack_a, 1'b0);
        check({tag, "_busy3"}, busy_a, 1'b0);
        check({tag, "_rdata3"}, rdata_a, exp_rd);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = 9'd0; wdata_a = 32'd0;
        req_b = 1'b0; we_b = 1'b0; addr_b = 9'd0; wdata_b = 32'd0;
        #1 rst = 1'b1;
        #2;
        check("rst_ack_a", ack_a, 1'b0);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_rdata_b", rdata_b, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back; write leaves rdata at zero.
        txn_a("wr10", 1'b1, 9'h010, 32'hDEADBEEF, 32'h0);
        step();
        check("idle_ack", ack_a, 1'b0);
        txn_a("rd10", 1'b0, 9'h010, 32'h0, 32'hDEADBEEF);
        txn_a("wr20", 1'b1, 9'h020, 32'hA5A5A5A5, 32'hDEADBEEF);
        txn_a("rd20", 1'b0, 9'h020, 32'h0, 32'hA5A5A5A5);

        // Reset mid-WAIT aborts a write.
        req_a = 1'b1; we_a = 1'b1; addr_a = 9'h020; wdata_a = 32'h12345678;
        step();
        check("abort_busy", busy_a, 1'b1);
        req_a = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("abort_busy_async", busy_a, 1'b0);
        check("abort_ack_async", ack_a, 1'b0);
        check("abort_rdata_async", rdata_a, 32'h0);
        step();
        check("abort_ack_e1", ack_a, 1'b0);
        rst = 1'b0;
        step();
        check("abort_ack_e2", ack_a, 1'b0);
        check("abort_busy_e2", busy_a, 1'b0);
        txn_a("rd20_post", 1'b0, 9'h020, 32'h0, 32'hA5A5A5A5);

        // Out of range for DEPTH=256: write ignored, read returns zero.
        txn_a("wr1ff", 1'b1, 9'h1FF, 32'hFFFFFFFF, 32'hA5A5A5A5);
        txn_a("rd1ff", 1'b0, 9'h1FF, 32'h0, 32'h0);

        // Zero wait states with sustained req: ack every other cycle.
        req_b = 1'b1; we_b = 1'b1; addr_b = 9'h005; wdata_b = 32'h11112222;
        step();
        check("b_wr5_ack", ack_b, 1'b1);
        check("b_wr5_busy", busy_b, 1'b1);
        check("b_wr5_rdata", rdata_b, 32'h0);
        we_b = 1'b0;
        step();
        check("b_gap1_ack", ack_b, 1'b0);
        check("b_gap1_busy", busy_b, 1'b0);
        step();
        check("b_rd5_ack", ack_b, 1'b1);
        check("b_rd5_rdata", rdata_b, 32'h11112222);
        we_b = 1'b1; addr_b = 9'h006; wdata_b = 32'h33334444;
        step();
        check("b_gap2_ack", ack_b, 1'b0);
        step();
        check("b_wr6_ack", ack_b, 1'b1);
        check("b_wr6_rdata", rdata_b, 32'h11112222);
        we_b = 1'b0;
        step();
        check("b_gap3_ack", ack_b, 1'b0);
        step();
        check("b_rd6_ack", ack_b, 1'b1);
        check("b_rd6_rdata", rdata_b, 32'h33334444);
        req_b = 1'b0;
        step();
        check("b_end1_ack", ack_b, 1'b0);
        step();
        check("b_end2_ack", ack_b, 1'b0);
        check("b_end2_busy", busy_b, 1'b0);
        check("b_end2_rdata", rdata_b, 32'h33334444);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
